// File: rtl/prog_logic_eval_pkg.sv
// ============================================================================
// Module      : prog_logic_eval_pkg
// Description : Shared state encoding and default truth table for prog_logic_eval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_logic_eval_pkg;

    localparam logic [0:0] C_LOADING = 1'b0;
    localparam logic [0:0] C_READY   = 1'b1;

    // 4-input even-parity XNOR: bit k is 1 when k has an even number of ones
    localparam logic [15:0] C_DEFAULT_TT_4 = 16'h9669;

endpackage

`default_nettype wire

// File: rtl/prog_logic_eval_tt_reg.sv
// ============================================================================
// Module      : tt_reg
// Description : Truth-table storage with single-bit write port and indexed read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_reg #(
    parameter int                   N_IN     = 4,
    parameter logic [(2**N_IN)-1:0] RESET_TT = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [N_IN-1:0] waddr_i,
    input  logic            wbit_i,
    input  logic [N_IN-1:0] raddr_i,
    output logic            rbit_o
);

    logic [(2**N_IN)-1:0] table_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_q <= RESET_TT;
        end else if (we_i) begin
            table_q[waddr_i] <= wbit_i;
        end
    end

    assign rbit_o = table_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/prog_logic_eval.sv
// ============================================================================
// Module      : prog_logic_eval
// Description : Programmable N_IN-input logic function with serial table load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_logic_eval
    import prog_logic_eval_pkg::*;
#(
    parameter int                   N_IN     = 4,
    parameter logic [(2**N_IN)-1:0] RESET_TT = C_DEFAULT_TT_4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic            load_bit,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [N_IN-1:0] in_vec,
    input  logic            in_valid,
    output logic            Y,
    output logic            y_valid,
    output logic            tt_ok
);

    localparam int TT_W  = 2**N_IN;
    localparam int IDX_W = $clog2(TT_W);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(TT_W - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             y_q,     y_d;
    logic             y_valid_q, y_valid_d;

    logic             w_we;
    logic             w_rd_bit;

    tt_reg #(
        .N_IN     (N_IN),
        .RESET_TT (RESET_TT)
    ) u_tt_reg (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_we),
        .waddr_i (idx_q),
        .wbit_i  (load_bit),
        .raddr_i (in_vec),
        .rbit_o  (w_rd_bit)
    );

    // load_start has priority over both loading and evaluation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        w_we      = 1'b0;

        if (load_start) begin
            state_d = C_LOADING;
            idx_d   = '0;
        end else if (state_q == C_LOADING) begin
            if (load_valid) begin
                w_we = 1'b1;
                if (idx_q == C_LAST_IDX) begin
                    state_d = C_READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end else if (in_valid) begin
            y_d       = w_rd_bit;
            y_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= C_READY;
            idx_q     <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign load_ready = (state_q == C_LOADING);
    assign tt_ok      = (state_q == C_READY);
    assign Y          = y_q;
    assign y_valid    = y_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_logic_eval.sv
// ============================================================================
// Module      : tb_prog_logic_eval
// Description : Directed self-checking bench for prog_logic_eval (N_IN = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_logic_eval;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic       load_bit;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] in_vec;
    logic       in_valid;
    logic       Y;
    logic       y_valid;
    logic       tt_ok;

    int n_tests = 0;
    int n_fail  = 0;

    prog_logic_eval #(
        .N_IN     (4),
        .RESET_TT (16'h9669)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_bit   (load_bit),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .in_vec     (in_vec),
        .in_valid   (in_valid),
        .Y          (Y),
        .y_valid    (y_valid),
        .tt_ok      (tt_ok)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_one(input logic b);
        load_valid = 1'b1;
        load_bit   = b;
        step();
        load_valid = 1'b0;
    endtask

    task automatic eval_chk(input string tag, input logic [3:0] v, input logic exp);
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq({tag, "_yv"}, 32'(y_valid), 32'd1);
        check_eq({tag, "_y"},  32'(Y),       32'(exp));
    endtask

    initial begin
        logic [15:0] pat;

        reset      = 1'b1;
        load_start = 1'b0;
        load_bit   = 1'b0;
        load_valid = 1'b0;
        in_vec     = 4'b0000;
        in_valid   = 1'b0;
        #1;
        check_eq("rst_tt_ok",   32'(tt_ok),      32'd1);
        check_eq("rst_ready",   32'(load_ready), 32'd0);
        check_eq("rst_y",       32'(Y),          32'd0);
        check_eq("rst_yvalid",  32'(y_valid),    32'd0);
        step();
        step();
        reset = 1'b0;

        // Default parity table, back-to-back evaluations right after reset
        eval_chk("def_0011", 4'b0011, 1'b1);
        eval_chk("def_0111", 4'b0111, 1'b0);
        step();
        check_eq("idle_yvalid", 32'(y_valid), 32'd0);
        check_eq("idle_yhold",  32'(Y),       32'd0);

        // Load 16'h8000, bit 0 first, with one stalled cycle mid-load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check_eq("ld_start_ready", 32'(load_ready), 32'd1);
        check_eq("ld_start_ttok",  32'(tt_ok),      32'd0);
        pat = 16'h8000;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                step();
                check_eq("ld_stall_ready", 32'(load_ready), 32'd1);
            end
            if (i == 15) check_eq("ld8000_pre_ttok", 32'(tt_ok), 32'd0);
            load_one(pat[i]);
        end
        check_eq("ld8000_ttok",  32'(tt_ok),      32'd1);
        check_eq("ld8000_ready", 32'(load_ready), 32'd0);
        // load_valid in READY must not touch the table
        load_valid = 1'b1;
        load_bit   = 1'b0;
        eval_chk("t8000_1111", 4'b1111, 1'b1);
        load_valid = 1'b0;
        eval_chk("t8000_1110", 4'b1110, 1'b0);
        eval_chk("t8000_1111b", 4'b1111, 1'b1);

        // Partial load of 8 bits with an ignored evaluation, then restart
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                in_vec   = 4'b0000;
                in_valid = 1'b1;
            end
            load_one(1'b0);
            if (i == 3) begin
                in_valid = 1'b0;
                check_eq("ld_eval_yvalid", 32'(y_valid), 32'd0);
                check_eq("ld_eval_ttok",   32'(tt_ok),   32'd0);
                check_eq("ld_eval_yhold",  32'(Y),       32'd1);
            end
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_eq("ldFFFF_pre_ttok", 32'(tt_ok), 32'd0);
            load_one(1'b1);
        end
        check_eq("ldFFFF_ttok", 32'(tt_ok), 32'd1);
        for (int v = 0; v < 16; v++) begin
            eval_chk($sformatf("tFFFF_%0d", v), 4'(v), 1'b1);
        end

        // load_start beats a simultaneous evaluation
        load_start = 1'b1;
        in_vec     = 4'b0101;
        in_valid   = 1'b1;
        step();
        load_start = 1'b0;
        in_valid   = 1'b0;
        check_eq("race_yvalid", 32'(y_valid),    32'd0);
        check_eq("race_ready",  32'(load_ready), 32'd1);
        check_eq("race_yhold",  32'(Y),          32'd1);

        // Reset mid-load restores the default table immediately
        for (int i = 0; i < 5; i++) load_one(1'b0);
        check_eq("pre_rst_ready", 32'(load_ready), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready",  32'(load_ready), 32'd0);
        check_eq("mid_rst_ttok",   32'(tt_ok),      32'd1);
        check_eq("mid_rst_y",      32'(Y),          32'd0);
        step();
        reset = 1'b0;
        eval_chk("rst_1001", 4'b1001, 1'b1);
        eval_chk("rst_1000", 4'b1000, 1'b0);
        eval_chk("rst_0110", 4'b0110, 1'b1);
        eval_chk("rst_1101", 4'b1101, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_logic_eval.md
PROG_LOGIC_EVAL -- requirements
Module: prog_logic_eval

Interface
REQ-001 Parameter N_IN, default 4, legal range 2..6: number of function inputs.
REQ-002 Parameter RESET_TT, width 2**N_IN, default 16'h9669: truth table loaded at reset; the default is 4-input even-parity XNOR.
REQ-003 Derived constant TT_W = 2**N_IN: truth-table size in bits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 load_start  in  1  begin a new truth-table load.
REQ-008 load_bit  in  1  serial truth-table bit.
REQ-009 load_valid  in  1  load_bit is valid this cycle.
REQ-010 load_ready  out  1  block accepts load_bit this cycle.
REQ-011 in_vec  in  N_IN  function inputs; in_vec[N_IN-1] is the MSB (A).
REQ-012 in_valid  in  1  evaluate in_vec this cycle.
REQ-013 Y  out  1  registered function result.
REQ-014 y_valid  out  1  Y is valid this cycle (one-cycle pulse).
REQ-015 tt_ok  out  1  a complete truth table is held.

Function
REQ-016 The FSM SHALL have two states: LOADING and READY.
REQ-017 A bit-index counter SHALL be ceil(log2(TT_W)) bits wide.
REQ-018 LOADING: load_ready=1 and tt_ok=0.
REQ-019 LOADING: each load_valid&load_ready cycle SHALL write load_bit to table[index], then increment index.
REQ-020 Table bit 0 SHALL be loaded first.
REQ-021 LOADING: accepting a bit at index TT_W-1 SHALL move to READY in the next cycle, with tt_ok=1 and index=0.
REQ-022 LOADING: load_valid=0 SHALL hold the state and index; there is no timeout.
REQ-023 load_start=1 in any state SHALL enter LOADING with index=0.
REQ-024 In the load_start cycle itself, no bit is written and no evaluation occurs.
REQ-025 A load_start during LOADING SHALL restart the load; previously loaded bits are overwritten as new bits arrive.
REQ-026 LOADING: in_valid SHALL be ignored; y_valid stays 0 and Y holds its value.
REQ-027 READY: load_ready=0, and load_valid is ignored.
REQ-028 READY: in_valid=1 and load_start=0 at edge k SHALL give Y=table[in_vec] and y_valid=1 after edge k+1 (latency 1).
REQ-029 READY: back-to-back in_valid cycles SHALL give back-to-back results at full throughput.
REQ-030 y_valid SHALL be 0 in any cycle not caused by REQ-028.
REQ-031 Y SHALL hold its last value when y_valid=0.
REQ-032 If load_start and in_valid are asserted together, load_start wins and the evaluation is dropped.

Reset
REQ-033 On reset assertion, asynchronously: state=READY, table=RESET_TT, index=0.
REQ-034 On reset assertion, asynchronously: Y=0, y_valid=0, tt_ok=1, load_ready=0.
REQ-035 A reset during LOADING SHALL discard the partial load and restore RESET_TT.
REQ-036 The first evaluation SHALL be accepted at the first clock edge after reset deasserts.

Structure
REQ-037 A shared package SHALL hold the state encoding (LOADING=1'b0, READY=1'b1) and the 4-input default-table constant 16'h9669.
REQ-038 The table storage and indexed read SHALL be the single sub-module tt_reg (parameter N_IN; write enable, write index, write bit, read index, async reset to RESET_TT).
REQ-039 The FSM, counter and output register SHALL live in the top module.

Verification (N_IN=4)
REQ-040 Reset, then in_vec=4'b0011 with in_vec=4'b0111 in consecutive cycles -> Y=1 then Y=0, each with y_valid=1, each one cycle after its input.
REQ-041 Load 16'h8000 (15 zeros, then a 1), then in_vec=4'b1111 and in_vec=4'b1110 -> Y=1 then Y=0; tt_ok=1 one cycle after the 16th accepted bit.
REQ-042 During a load, in_valid=1 with in_vec=4'b0000 -> y_valid stays 0 and tt_ok=0.
REQ-043 Load 8 bits, assert load_start, then load 16 bits of 16'hFFFF -> READY after exactly 16 accepted bits, and every in_vec gives Y=1.
REQ-044 In READY, load_start and in_valid in the same cycle -> no y_valid pulse, and load_ready=1 next cycle.
REQ-045 Assert reset after 5 loaded bits -> state READY, table=16'h9669 (in_vec=4'b1001 gives Y=1), and load_ready=0 immediately.
